alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 99 +++++++++
 tb/tb_alu_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked 32-bit ALU (add/sub/and/or, optional 32-cycle shift-add MUL under ALU_SEQ_MUL_EN)
module alu_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        Zero_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] data_q, data_d, alu_res;
  logic accept;
`ifdef ALU_SEQ_MUL_EN
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, partial;
  logic [5:0] cnt_q, cnt_d;
`endif
  assign ready_o = rst_n_i & (state_q == IDLE);
  assign accept = valid_i & ready_o;
  assign valid_o = state_q == DONE;
  assign data_o = data_q;
  assign Zero_o = valid_o & (data_q == '0);
  // single-cycle ops; unused codes (and MUL when not built) fall through to add
  always_comb begin
    alu_res = ALUCtrl_i == 3'b010 ? data1_i - data2_i :
              ALUCtrl_i == 3'b011 ? data1_i & data2_i :
              ALUCtrl_i == 3'b100 ? data1_i | data2_i :
                                    data1_i + data2_i;
  end
  // next state: accept in IDLE, iterate shift-add in BUSY, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    data_d = data_q;
`ifdef ALU_SEQ_MUL_EN
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    partial = acc_q + (b_q[0] ? a_q : '0);
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = DONE;
        data_d = alu_res;
`ifdef ALU_SEQ_MUL_EN
        if (ALUCtrl_i == 3'b110) begin
          state_d = BUSY;
          data_d = data_q;
          a_d = data1_i;
          b_d = data2_i;
          acc_d = '0;
          cnt_d = '0;
        end
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        acc_d = partial;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          data_d = partial;
        end
      end
`endif
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any in-flight multiply
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q <= '0;
`ifdef ALU_SEQ_MUL_EN
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q <= data_d;
`ifdef ALU_SEQ_MUL_EN
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq
module tb_alu_seq;
  logic clk_i = 0, rst_n_i = 0, valid_i = 0, ready_i = 1;
  logic [2:0] ALUCtrl_i = 0;
  logic [31:0] data1_i = 0, data2_i = 0, data_o;
  logic ready_o, valid_o, Zero_o;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  alu_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .Zero_o(Zero_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_SEQ_MUL_EN
    if (op == 3'b110) return a * b;
`endif
    return op == 3'b010 ? a - b : op == 3'b011 ? a & b : op == 3'b100 ? a | b : a + b;
  endfunction
  function automatic int lat_of(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    if (op == 3'b110) return 33;
`endif
    return 1;
  endfunction
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    logic rl;
    logic [31:0] exp;
    ready_i = hold == 0;
    valid_i = 1;
    ALUCtrl_i = op;
    data1_i = a;
    data2_i = b;
    chk({tag, "_ready_idle"}, 32'(ready_o), 1);
    q.push_back(model(op, a, b));
    tick;
    valid_i = 0;
    ALUCtrl_i = 3'b011;
    data1_i = $urandom;
    data2_i = $urandom;
    n = 1;
    rl = 1;
    while (!valid_o && n < 40) begin
      if (ready_o) rl = 0;
      tick;
      n++;
    end
    if (ready_o) rl = 0;
    chk({tag, "_latency"}, 32'(n), 32'(lat_of(op)));
    chk({tag, "_ready_low"}, 32'(rl), 1);
    chk({tag, "_sb_depth"}, 32'(q.size()), 1);
    exp = q.size() > 0 ? q.pop_front() : 32'hx;
    chk({tag, "_data"}, data_o, exp);
    chk({tag, "_zero"}, 32'(Zero_o), 32'(exp == 0));
    for (int i = 0; i < hold; i++) begin
      valid_i = i[0];
      tick;
      chk({tag, "_hold_valid"}, 32'(valid_o), 1);
      chk({tag, "_hold_data"}, data_o, exp);
    end
    ready_i = 1;
    valid_i = 0;
    tick;
    chk({tag, "_release_valid"}, 32'(valid_o), 0);
    chk({tag, "_release_ready"}, 32'(ready_o), 1);
  endtask
  initial begin
    int seen;
    #1;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_zero", 32'(Zero_o), 0);
    tick;
    #3 rst_n_i = 1;
    tick;
    chk("post_rst_ready", 32'(ready_o), 1);
    chk("post_rst_valid", 32'(valid_o), 0);
    do_op("add_wrap", 3'b001, 32'hFFFFFFFF, 32'h1, 0);
    do_op("sub", 3'b010, 32'd5, 32'd7, 0);
    do_op("and", 3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    do_op("or", 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    do_op("op000", 3'b000, 32'h12345678, 32'h11111111, 0);
    do_op("op101", 3'b101, 32'h80000000, 32'h80000000, 0);
    do_op("op111", 3'b111, 32'd100, 32'd23, 0);
`ifdef ALU_SEQ_MUL_EN
    do_op("mul", 3'b110, 32'h00012345, 32'h00010000, 0);
    do_op("mul_neg", 3'b110, 32'hFFFFFFFF, 32'd3, 0);
`else
    do_op("op110_add", 3'b110, 32'd2, 32'd3, 0);
`endif
    do_op("backpressure", 3'b001, 32'd3, 32'd4, 5);
    ready_i = 0;
    valid_i = 1;
    ALUCtrl_i = 3'b001;
    data1_i = 32'd5;
    data2_i = 32'd6;
    tick;
    valid_i = 0;
    chk("done_pre_rst_data", data_o, 32'd11);
    rst_n_i = 0;
    #1;
    chk("done_rst_valid", 32'(valid_o), 0);
    chk("done_rst_data", data_o, 0);
    chk("done_rst_ready", 32'(ready_o), 0);
    #2 rst_n_i = 1;
    tick;
    chk("done_rst_idle", 32'(ready_o), 1);
`ifdef ALU_SEQ_MUL_EN
    ready_i = 1;
    valid_i = 1;
    ALUCtrl_i = 3'b110;
    data1_i = 32'd7;
    data2_i = 32'd9;
    tick;
    valid_i = 0;
    repeat (10) tick;
    rst_n_i = 0;
    #1;
    chk("mul_rst_valid", 32'(valid_o), 0);
    chk("mul_rst_data", data_o, 0);
    #2 rst_n_i = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (valid_o) seen++;
    end
    chk("mul_rst_no_stale", 32'(seen), 0);
`endif
    do_op("add_after_rst", 3'b001, 32'd1, 32'd1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
